// File: rtl/noc_output_port_arbiter.sv
// Round-robin arbiter with one-flit output register for a router port.
// Ports: req_valid/req_flit/req_ready in, out_flit/out_valid/out_ready out, telemetry.
module noc_output_port_arbiter #(
  parameter int FLIT_WIDTH = 64,
  parameter int NUM_REQ    = 5,
  parameter int CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FLIT_WIDTH-1:0] req_flit,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [FLIT_WIDTH-1:0]         out_flit,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2:0]                    grant_idx,
  output logic [CNT_W-1:0]              flits_out_count,
  output logic [CNT_W-1:0]              stall_arb_count,
  output logic [CNT_W-1:0]              stall_bp_count
);

  logic [2:0]            rr_ptr;
  logic                  load;
  logic                  win_found;
  logic [2:0]            win_idx;
  logic [FLIT_WIDTH-1:0] win_flit;
  logic                  accept;
  logic [3:0]            nxt_ptr;
  logic [3:0]            pop;
  logic [3:0]            arb_inc;
  logic                  out_hs;
  logic                  bp_stall;
  int                    scan;

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] a,
    input logic [3:0]       inc
  );
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(inc);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Register is free when empty or draining this cycle.
  assign load = !out_valid || out_ready;

  // Scan from rr_ptr upward, wrapping, first valid wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_flit  = '0;
    scan      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = int'(rr_ptr) + k;
      if (scan >= NUM_REQ)
        scan = scan - NUM_REQ;
      if (!win_found && req_valid[scan]) begin
        win_found = 1'b1;
        win_idx   = 3'(scan);
        win_flit  = req_flit[scan*FLIT_WIDTH +: FLIT_WIDTH];
      end
    end
  end

  assign accept    = load && win_found;
  assign req_ready = accept ? (NUM_REQ'(1) << win_idx)
                            : '0;
  assign nxt_ptr   = {1'b0, win_idx} + 4'd1;

  assign pop      = 4'($countones(req_valid));
  // Every valid requester but the winner lost this cycle.
  assign arb_inc  = (load && pop >= 4'd2) ? pop - 4'd1
                                          : 4'd0;
  assign out_hs   = out_valid && out_ready;
  assign bp_stall = out_valid && !out_ready
                    && (|req_valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_flit        <= '0;
      out_valid       <= 1'b0;
      grant_idx       <= '0;
      rr_ptr          <= '0;
      flits_out_count <= '0;
      stall_arb_count <= '0;
      stall_bp_count  <= '0;
    end else begin
      if (accept) begin
        out_flit  <= win_flit;
        out_valid <= 1'b1;
        grant_idx <= win_idx;
        rr_ptr    <= (nxt_ptr == 4'(NUM_REQ)) ? 3'd0
                                              : nxt_ptr[2:0];
      end else if (load) begin
        out_valid <= 1'b0;
      end
      if (out_hs)
        flits_out_count <= sat_add(flits_out_count, 4'd1);
      if (arb_inc != 4'd0)
        stall_arb_count <= sat_add(stall_arb_count, arb_inc);
      if (bp_stall)
        stall_bp_count <= sat_add(stall_bp_count, 4'd1);
    end
  end

endmodule

// File: tb/tb_noc_output_port_arbiter.sv
// Directed bench for noc_output_port_arbiter.
// Second instance with CNT_W=4 covers counter saturation.
module tb_noc_output_port_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b0;

  logic [4:0]   valid = '0;
  logic [319:0] flit = '0;
  logic [4:0]   rdy;
  logic [63:0]  oflit;
  logic         ovalid;
  logic         oready = 1'b0;
  logic [2:0]   gidx;
  logic [31:0]  fc, ac, bc;

  logic [4:0]   s_valid = '0;
  logic [319:0] s_flit = '0;
  logic [4:0]   s_rdy;
  logic [63:0]  s_oflit;
  logic         s_ovalid;
  logic         s_oready = 1'b0;
  logic [2:0]   s_gidx;
  logic [3:0]   s_fc, s_ac, s_bc;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  noc_output_port_arbiter u_dut (
    .clk(clk), .reset(reset),
    .req_valid(valid), .req_flit(flit),
    .req_ready(rdy), .out_flit(oflit),
    .out_valid(ovalid), .out_ready(oready),
    .grant_idx(gidx), .flits_out_count(fc),
    .stall_arb_count(ac), .stall_bp_count(bc)
  );

  noc_output_port_arbiter #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset),
    .req_valid(s_valid), .req_flit(s_flit),
    .req_ready(s_rdy), .out_flit(s_oflit),
    .out_valid(s_ovalid), .out_ready(s_oready),
    .grant_idx(s_gidx), .flits_out_count(s_fc),
    .stall_arb_count(s_ac), .stall_bp_count(s_bc)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid    = '0;
    s_valid  = '0;
    oready   = 1'b0;
    s_oready = 1'b0;
    reset    = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  function automatic logic [63:0] fexp(input int i);
    return 64'hC0DE_0000_0000_0000 + 64'(i);
  endfunction

  initial begin
    int hs;
    int acc;
    logic [4:0] last_acc;
    logic [63:0] held;

    for (int i = 0; i < 5; i++)
      flit[i*64 +: 64] = fexp(i);
    s_flit = flit;

    do_reset();
    check("rst_valid", 64'(ovalid), 64'd0);
    check("rst_flit", oflit, 64'd0);
    check("rst_gidx", 64'(gidx), 64'd0);
    check("rst_cnt", 64'(fc | ac | bc), 64'd0);

    // 1: single requester
    valid  = 5'b00001;
    oready = 1'b1;
    #1;
    check("t1_rdy", 64'(rdy), 64'h1);
    step();
    check("t1_valid", 64'(ovalid), 64'd1);
    check("t1_flit", oflit, fexp(0));
    check("t1_gidx", 64'(gidx), 64'd0);
    valid = '0;
    step();
    check("t1_fc", 64'(fc), 64'd1);
    check("t1_empty", 64'(ovalid), 64'd0);

    // 2: all requesters, round robin from 0
    do_reset();
    valid  = 5'b11111;
    oready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("t2_rdy", 64'(rdy), 64'(5'b1 << (k % 5)));
      step();
      check("t2_gidx", 64'(gidx), 64'(k % 5));
      check("t2_flit", oflit, fexp(k % 5));
    end
    check("t2_arb", 64'(ac), 64'd40);
    check("t2_fc", 64'(fc), 64'd9);

    // 3: backpressure for three cycles
    held   = oflit;
    valid  = 5'b00110;
    oready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t3_rdy", 64'(rdy), 64'd0);
      step();
      check("t3_flit", oflit, held);
    end
    check("t3_bp", 64'(bc), 64'd3);
    check("t3_arb", 64'(ac), 64'd40);
    oready = 1'b1;
    #1;
    check("t3_ptr", 64'(rdy), 64'(5'b00010));
    step();
    check("t3_gidx", 64'(gidx), 64'd1);
    check("t3_fc", 64'(fc), 64'd10);
    check("t3_arb2", 64'(ac), 64'd41);

    // 4: zero-bubble stream from requester 2
    do_reset();
    valid  = 5'b00100;
    oready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      flit[2*64 +: 64] = 64'hBEEF_0000 + 64'(k);
      #1;
      check("t4_rdy", 64'(rdy), 64'(5'b00100));
      step();
      check("t4_flit", oflit, 64'hBEEF_0000 + 64'(k));
    end
    valid = '0;
    flit[2*64 +: 64] = fexp(2);
    step();
    check("t4_fc", 64'(fc), 64'd8);

    // 5: reset pulse with a flit in flight
    valid  = 5'b11000;
    oready = 1'b0;
    step();
    check("t5_pre", 64'(ovalid), 64'd1);
    check("t5_pgidx", 64'(gidx), 64'd3);
    reset = 1'b0;
    #1;
    check("t5_valid", 64'(ovalid), 64'd0);
    check("t5_cnt", 64'(fc | ac | bc), 64'd0);
    check("t5_flit", oflit, 64'd0);
    #2;
    reset  = 1'b1;
    valid  = 5'b01010;
    oready = 1'b1;
    #1;
    check("t5_rdy", 64'(rdy), 64'(5'b00010));
    step();
    check("t5_gidx", 64'(gidx), 64'd1);
    check("t5_oflit", oflit, fexp(1));

    // 6: saturation with CNT_W=4
    do_reset();
    s_valid  = 5'b00001;
    s_oready = 1'b1;
    repeat (21) step();
    check("t6_sat", 64'(s_fc), 64'd15);
    check("t6_arb", 64'(s_ac), 64'd0);

    do_reset();
    hs = 0;
    acc = 0;
    last_acc = '0;
    for (int k = 0; k < 200; k++) begin
      s_valid  = (s_valid & ~last_acc)
                 | 5'($urandom());
      s_oready = 1'($urandom_range(0, 1));
      #1;
      last_acc = s_valid & s_rdy;
      if (last_acc != '0) acc++;
      if (s_ovalid && s_oready) hs++;
      step();
    end
    check("t6_fc",
          64'(s_fc), 64'((hs > 15) ? 15 : hs));
    check("t6_le", 64'(int'(s_fc) <= acc), 64'd1);
    check("t6_inv",
          64'(acc - int'(s_ovalid)), 64'(hs));

    $display("%0d/%0d checks passed",
             n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
